pc_bp_regdump: RTL and testbench
================================

// Module: pc_bp_regdump
// PURPOSE
//  Synthesizable successor to the bench-side register dump that fires on fixed PCs.
//  Holds NUM_BP programmable PC breakpoints and watches the retiring PC of the core.
//  On a hit it stalls the core and streams one header beat plus NUM_REGS register
//  values over a valid/ready port. Sits between the core, its register-file debug
//  read port, and the debug/trace sink.
// PARAMETERS
//  XLEN      32  data/address width of pc, breakpoints, register values
//  NUM_BP    4   number of breakpoint comparators (>=1)
//  NUM_REGS  32  registers streamed per dump (<=32; index 0..NUM_REGS-1)
//  CNT_W     16  width of hit and missed counters
// PORTS
//  clk         in   1             clock, all flops on posedge
//  nrst        in   1             asynchronous active-low reset
//  pc          in   XLEN          PC of retiring instruction
//  pc_valid    in   1             pc is a real retirement this cycle
//  bp_we       in   1             write breakpoint entry bp_idx
//  bp_idx      in   max(1,$clog2(NUM_BP))  entry selector
//  bp_addr     in   XLEN          breakpoint PC to store
//  bp_en       in   1             enable bit stored with bp_addr
//  rf_raddr    out  5             register-file debug read address
//  rf_rdata    in   XLEN          register-file read data (combinational, same cycle)
//  core_stall  out  1             freeze core retirement/writeback
//  dump_valid  out  1             stream beat valid
//  dump_ready  in   1             sink accepts beat
//  dump_data   out  XLEN          header: captured PC; body: register value
//  dump_hdr    out  1             beat is header
//  dump_idx    out  5             body: register index; header: breakpoint id
//  dump_last   out  1             final beat (register NUM_REGS-1)
//  busy        out  1             state != IDLE
//  hit_count   out  CNT_W         dumps started, saturating
//  miss_count  out  CNT_W         hits dropped while busy, saturating
// BEHAVIOUR
//  Reset (async, nrst=0): state=IDLE, all bp entries addr=0 en=0, counters=0.
//   All outputs 0: core_stall, dump_valid, dump_hdr, dump_last, busy, rf_raddr, dump_data.
//  Hit: pc_valid & bp_en[k] & (bp_addr[k]==pc) for any k. Lowest k wins.
//   Match uses entry contents before any same-cycle bp_we.
//  bp_we writes {bp_addr,bp_en} at posedge. Allowed in any state. Used from next cycle.
//  FSM IDLE -> HDR -> BODY -> IDLE:
//   IDLE: on hit, capture pc and k, hit_count++ (sat), go to HDR next cycle.
//   HDR: dump_valid=1, dump_hdr=1, dump_data=captured pc, dump_idx=k.
//    On valid&ready, go to BODY with reg index r=0.
//   BODY: dump_valid=1, rf_raddr=r, dump_data=rf_rdata, dump_idx=r.
//    dump_last=(r==NUM_REGS-1). On valid&ready: r++; after the last beat, go to IDLE.
//  core_stall=busy, asserted from the cycle after the hit.
//   The hit instruction's own retirement completes.
//   Register values are those after the hit instruction.
//  Valid/ready rules:
//   Once valid rises, data, idx, hdr and last stay stable until accepted.
//   The core is stalled, so rf_rdata is stable.
//   Valid never drops without a transfer. Ready may toggle freely.
//   Back-to-back acceptance gives 1 beat/cycle.
//   A full dump is NUM_REGS+1 beats, minimum NUM_REGS+1 cycles in HDR/BODY.
//  Hit while busy or in the IDLE exit cycle: not dumped, miss_count++ (sat).
//   pc_valid should be 0 while stalled; any hit still counts as a miss.
//  Counters saturate at 2^CNT_W-1 and never wrap.
//  nrst asserted mid-dump: immediate abort to IDLE, stall and valid drop asynchronously.
//  Register 0 is streamed like any other (value as returned by rf_rdata).
// TESTING
//  1. Reset: nrst=0 mid-dump -> busy=0, core_stall=0, dump_valid=0, counters=0 at once.
//  2. Program bp0=0x0000_00FC en=1, retire pc=0xFC, ready=1 ->
//     header {data=0xFC, idx=0}, then 32 beats idx 0..31, last on idx 31.
//     33 beats in 33 cycles, stall released next cycle, hit_count=1.
//  3. bp1=0x174 and bp3=0x174 both enabled, hit -> header idx=1.
//     Disable bp1 same cycle as hit -> still idx=1. Next hit at 0x174 -> idx=3.
//  4. Random ready (50%) during dump -> data/idx/last held while valid&!ready.
//     Register values match the reference model; no beat lost or duplicated.
//  5. Hits while busy (pc_valid forced) x3 -> miss_count=3, hit_count unchanged.
//     Preload miss_count near max with CNT_W=4 and 20 misses -> saturates at 15.
//  6. bp_en=0 entry with matching pc -> no dump.
//     pc_valid=0 with matching pc -> no dump, counters unchanged.

Source files
------------

// File: rtl/pc_bp_regdump.sv
// PC breakpoint unit: on a retiring-PC match it stalls the core and streams a
// header beat plus NUM_REGS register-file values over a valid/ready port.
module pc_bp_regdump #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_BP   = 4,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned CNT_W    = 16,
  localparam int unsigned IDX_W   = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [XLEN-1:0]  pc,
  input  logic             pc_valid,
  input  logic             bp_we,
  input  logic [IDX_W-1:0] bp_idx,
  input  logic [XLEN-1:0]  bp_addr,
  input  logic             bp_en,
  output logic [4:0]       rf_raddr,
  input  logic [XLEN-1:0]  rf_rdata,
  output logic             core_stall,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [XLEN-1:0]  dump_data,
  output logic             dump_hdr,
  output logic [4:0]       dump_idx,
  output logic             dump_last,
  output logic             busy,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

  localparam logic [4:0] LAST_R = 5'(NUM_REGS - 1);

  state_t            state;
  logic [4:0]        r;
  logic [XLEN-1:0]   cap_pc;
  logic [IDX_W-1:0]  cap_k;
  logic [XLEN-1:0]   bp_addr_q [NUM_BP];
  logic [NUM_BP-1:0] bp_en_q;
  logic              hit;
  logic [IDX_W-1:0]  hit_k;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int unsigned k = 0; k < NUM_BP; k++) bp_addr_q[k] <= '0;
      bp_en_q <= '0;
    end else if (bp_we && (32'(bp_idx) < NUM_BP)) begin
      bp_addr_q[bp_idx] <= bp_addr;
      bp_en_q[bp_idx]   <= bp_en;
    end
  end

  // Scan downwards so the lowest matching entry is the one left in hit_k.
  always_comb begin
    hit   = 1'b0;
    hit_k = '0;
    for (int unsigned k = NUM_BP; k > 0; k--) begin
      if (pc_valid && bp_en_q[k-1] && (bp_addr_q[k-1] == pc)) begin
        hit   = 1'b1;
        hit_k = IDX_W'(k - 1);
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      r          <= '0;
      cap_pc     <= '0;
      cap_k      <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            state  <= HDR;
            cap_pc <= pc;
            cap_k  <= hit_k;
            if (hit_count != '1) hit_count <= hit_count + 1'b1;
          end
        end
        HDR: begin
          if (dump_ready) begin
            state <= BODY;
            r     <= '0;
          end
        end
        BODY: begin
          if (dump_ready) begin
            r <= r + 1'b1;
            if (r == LAST_R) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (hit && (state != IDLE) && (miss_count != '1)) miss_count <= miss_count + 1'b1;
    end
  end

  // Outputs decode only registered state, so reset removes them asynchronously.
  assign busy       = (state != IDLE);
  assign core_stall = busy;
  assign dump_valid = busy;
  assign dump_hdr   = (state == HDR);
  assign dump_last  = (state == BODY) && (r == LAST_R);
  assign rf_raddr   = (state == BODY) ? r : '0;

  always_comb begin
    dump_data = '0;
    dump_idx  = '0;
    case (state)
      HDR: begin
        dump_data = cap_pc;
        dump_idx  = 5'(cap_k);
      end
      BODY: begin
        dump_data = rf_rdata;
        dump_idx  = r;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pc_bp_regdump.sv
// Randomized self-checking bench for pc_bp_regdump; expected beats come from a
// queue built from breakpoint rules and a behavioural register file.
module tb_pc_bp_regdump;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned CNT_W    = 4;
  localparam int          SAT      = 15;

  logic             clk = 1'b0;
  logic             nrst = 1'b0;
  logic [XLEN-1:0]  pc = '0;
  logic             pc_valid = 1'b0;
  logic             bp_we = 1'b0;
  logic [1:0]       bp_idx = '0;
  logic [XLEN-1:0]  bp_addr = '0;
  logic             bp_en = 1'b0;
  logic [4:0]       rf_raddr;
  logic [XLEN-1:0]  rf_rdata;
  logic             core_stall;
  logic             dump_valid;
  logic             dump_ready = 1'b0;
  logic [XLEN-1:0]  dump_data;
  logic             dump_hdr;
  logic [4:0]       dump_idx;
  logic             dump_last;
  logic             busy;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  idx;
    logic        hdr;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] rf [32];
  int          checks = 0;
  int          errors = 0;
  int          m_hits = 0;
  int          m_miss = 0;

  pc_bp_regdump #(.XLEN(XLEN), .NUM_BP(4), .NUM_REGS(NUM_REGS), .CNT_W(CNT_W)) dut (
    .clk(clk), .nrst(nrst), .pc(pc), .pc_valid(pc_valid),
    .bp_we(bp_we), .bp_idx(bp_idx), .bp_addr(bp_addr), .bp_en(bp_en),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .core_stall(core_stall),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
    .dump_hdr(dump_hdr), .dump_idx(dump_idx), .dump_last(dump_last),
    .busy(busy), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;
  assign rf_rdata = rf[rf_raddr];

  task automatic fill_rf();
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
  endtask

  task automatic program_bp(input int idx, input logic [31:0] addr, input logic en);
    bp_we = 1'b1; bp_idx = 2'(idx); bp_addr = addr; bp_en = en;
    @(negedge clk);
    bp_we = 1'b0;
  endtask

  // Model: a dump is one header then every register in index order.
  task automatic expect_dump(input logic [31:0] hpc, input int k);
    beat_t b;
    b.data = hpc; b.idx = 5'(k); b.hdr = 1'b1; b.last = 1'b0;
    exp_q.push_back(b);
    for (int i = 0; i < NUM_REGS; i++) begin
      b.data = rf[i]; b.idx = 5'(i); b.hdr = 1'b0; b.last = (i == NUM_REGS - 1);
      exp_q.push_back(b);
    end
    m_hits = (m_hits < SAT) ? m_hits + 1 : SAT;
  endtask

  task automatic drain(input bit rnd, output int ncyc);
    bit acc;
    ncyc = 0;
    while (exp_q.size() > 0 && ncyc < 400) begin
      checks++;
      if (dump_valid !== 1'b1 || core_stall !== 1'b1) begin
        errors++;
        $display("FAIL drain_valid: valid=%b stall=%b required 1/1 (%0d beats left)",
                 dump_valid, core_stall, exp_q.size());
      end
      checks++;
      if (dump_data !== exp_q[0].data || dump_idx !== exp_q[0].idx ||
          dump_hdr !== exp_q[0].hdr || dump_last !== exp_q[0].last) begin
        errors++;
        $display("FAIL beat: data=%h idx=%0d hdr=%b last=%b required data=%h idx=%0d hdr=%b last=%b",
                 dump_data, dump_idx, dump_hdr, dump_last,
                 exp_q[0].data, exp_q[0].idx, exp_q[0].hdr, exp_q[0].last);
      end
      dump_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      acc = dump_valid && dump_ready;
      @(negedge clk);
      ncyc++;
      if (acc) void'(exp_q.pop_front());
    end
    dump_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_counters(input string name);
    checks++;
    if (hit_count !== CNT_W'(m_hits) || miss_count !== CNT_W'(m_miss)) begin
      errors++;
      $display("FAIL %s: hit=%0d miss=%0d required hit=%0d miss=%0d",
               name, hit_count, miss_count, m_hits, m_miss);
    end
  endtask

  task automatic test_reset();
    fill_rf();
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({core_stall, dump_valid, dump_hdr, dump_last, busy} !== 5'b0 ||
        rf_raddr !== 5'd0 || dump_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: stall=%b valid=%b hdr=%b last=%b busy=%b raddr=%0d data=%h required all 0",
               core_stall, dump_valid, dump_hdr, dump_last, busy, rf_raddr, dump_data);
    end
    check_counters("reset_counters");
    nrst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_dump();
    int n;
    program_bp(0, 32'h0000_00FC, 1'b1);
    fill_rf();
    pc = 32'hFC; pc_valid = 1'b1;
    expect_dump(32'hFC, 0);
    @(negedge clk);
    pc_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || core_stall !== 1'b1) begin
      errors++;
      $display("FAIL stall_after_hit: busy=%b stall=%b required 1/1", busy, core_stall);
    end
    drain(1'b0, n);
    checks++;
    if (n != NUM_REGS + 1) begin
      errors++;
      $display("FAIL dump_cycles: %0d required %0d", n, NUM_REGS + 1);
    end
    checks++;
    if (busy !== 1'b0 || core_stall !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: busy=%b stall=%b required 0/0", busy, core_stall);
    end
    check_counters("basic_counters");
  endtask

  task automatic test_priority();
    int n;
    program_bp(1, 32'h174, 1'b1);
    program_bp(3, 32'h174, 1'b1);
    fill_rf();
    pc = 32'h174; pc_valid = 1'b1;
    bp_we = 1'b1; bp_idx = 2'd1; bp_addr = 32'h174; bp_en = 1'b0;
    expect_dump(32'h174, 1);
    @(negedge clk);
    pc_valid = 1'b0; bp_we = 1'b0;
    drain(1'b0, n);
    fill_rf();
    pc = 32'h174; pc_valid = 1'b1;
    expect_dump(32'h174, 3);
    @(negedge clk);
    pc_valid = 1'b0;
    drain(1'b0, n);
    check_counters("priority_counters");
  endtask

  task automatic test_random_ready();
    int n, j, k;
    logic [31:0] a2, hpc;
    a2 = ($urandom & 32'hFFFF_F000) | 32'h400;
    program_bp(2, a2, 1'b1);
    for (int t = 0; t < 4; t++) begin
      for (int c = 0; c < 5; c++) begin
        pc = $urandom | 32'h1; pc_valid = 1'b1;
        @(negedge clk);
      end
      pc_valid = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL odd_pc_no_hit: busy=%b required 0", busy);
      end
      fill_rf();
      j = $urandom_range(0, 2);
      hpc = (j == 0) ? 32'hFC : (j == 1) ? a2 : 32'h174;
      k   = (j == 0) ? 0 : (j == 1) ? 2 : 3;
      pc = hpc; pc_valid = 1'b1;
      expect_dump(hpc, k);
      @(negedge clk);
      pc_valid = 1'b0;
      drain(1'b1, n);
    end
    check_counters("random_counters");
  endtask

  task automatic test_miss();
    int n;
    fill_rf();
    pc = 32'hFC; pc_valid = 1'b1;
    expect_dump(32'hFC, 0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      pc_valid = 1'b1; pc = 32'hFC;
      m_miss = (m_miss < SAT) ? m_miss + 1 : SAT;
      @(negedge clk);
    end
    pc_valid = 1'b0;
    check_counters("miss_three");
    drain(1'b1, n);
    pc = 32'hFC; pc_valid = 1'b1;
    expect_dump(32'hFC, 0);
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      pc_valid = 1'b1;
      m_miss = (m_miss < SAT) ? m_miss + 1 : SAT;
      @(negedge clk);
    end
    pc_valid = 1'b0;
    checks++;
    if (miss_count !== 4'd15) begin
      errors++;
      $display("FAIL miss_saturate: miss=%0d required 15", miss_count);
    end
    drain(1'b0, n);
    check_counters("miss_after");
  endtask

  task automatic test_no_dump();
    program_bp(2, 32'h200, 1'b0);
    pc = 32'h200; pc_valid = 1'b1;
    @(negedge clk);
    pc_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL disabled_entry: busy=%b required 0", busy);
    end
    pc = 32'hFC; pc_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL pc_valid_low: busy=%b required 0", busy);
    end
    check_counters("no_dump_counters");
  endtask

  task automatic test_reset_mid_dump();
    pc = 32'hFC; pc_valid = 1'b1;
    m_hits = (m_hits < SAT) ? m_hits + 1 : SAT;
    @(negedge clk);
    pc_valid = 1'b0;
    dump_ready = 1'b1;
    repeat (5) @(negedge clk);
    dump_ready = 1'b0;
    #2 nrst = 1'b0;
    #1;
    m_hits = 0; m_miss = 0;
    checks++;
    if (busy !== 1'b0 || core_stall !== 1'b0 || dump_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_abort: busy=%b stall=%b valid=%b required 0/0/0", busy, core_stall, dump_valid);
    end
    check_counters("async_abort_counters");
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    pc = 32'hFC; pc_valid = 1'b1;
    @(negedge clk);
    pc_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_cleared: busy=%b required 0", busy);
    end
    check_counters("post_reset_counters");
  endtask

  initial begin
    test_reset();
    test_basic_dump();
    test_priority();
    test_random_ready();
    test_miss();
    test_no_dump();
    test_reset_mid_dump();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
